md5_block_padder: RTL and testbench
===================================

# md5_block_padder

- Message front end for the MD5 core: accepts a message as a byte stream and emits fully padded 512-bit blocks (0x80 marker, zero fill, 64-bit little-endian bit length).
- Sits between the byte source and the MD5 block core; drives the core's block input and start/continue control through a valid/ready block handshake.
- One block is buffered at a time; the producer is stalled while a block waits to be consumed.

## Interface
Parameters:
- `LEN_W`, default 64: width of the message bit-length counter; the length field is zero-extended or truncated to 64 bits.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: reset, synchronous and active-high.
- `in_data`, in, 8: message byte.
- `in_valid`, in, 1: byte beat valid.
- `in_last`, in, 1: beat is the final one of the message.
- `in_zero`, in, 1: beat carries no byte. Legal only with `in_last`; used for zero-length messages or tail-only ends.
- `in_ready`, out, 1: a beat is accepted on `in_valid && in_ready`.
- `blk_data`, out, 512: block. Byte k of the block is at `blk_data[8k+7:8k]`.
- `blk_valid`, out, 1: block available.
- `blk_first`, out, 1: first block of a message. The core must restart chaining from the initial values.
- `blk_last`, out, 1: final block of a message. The core's digest after this block is the result.
- `blk_ready`, in, 1: block consumed on `blk_valid && blk_ready`.

## Operation
- **FSM states:** FILL, PAD, LENBLK, EMIT.
- **FILL**
  - `in_ready`=1.
  - Each accepted non-zero beat writes `in_data` at index `idx` (0..63), then `idx`++ and `byte_cnt`++ (`LEN_W-3` bits, wraps).
  - When `idx`=63 is written without `in_last`: go to EMIT with `blk_last`=0.
  - Accepted beat with `in_last`: go to PAD, after writing the byte if `in_zero`=0.
- **PAD** (one cycle). Let p be the next free index.
  - If p ≤ 55: byte p=0x80, bytes p+1..55=0, bytes 56..63 = `{byte_cnt,3'b000}` little-endian. Go to EMIT with `blk_last`=1.
  - If 56 ≤ p ≤ 63: byte p=0x80, rest 0. Go to EMIT with `blk_last`=0, then LENBLK.
  - If p=64 (last byte filled the block): emit the data block non-last first, then LENBLK with byte 0=0x80.
- **LENBLK** (one cycle): zero block, 0x80 at byte 0 if still owed, length at bytes 56..63. Go to EMIT with `blk_last`=1.
- **EMIT**
  - `blk_valid`=1; `blk_data`, `blk_first` and `blk_last` are held stable until the handshake.
  - On handshake: clear the buffer to zero and set `idx`=0.
  - Next state: FILL if the message is unfinished or the last block was sent, otherwise LENBLK.
  - `byte_cnt` clears after the `blk_last` handshake.
- **`blk_first`:** 1 for the first block emitted after reset or after a `blk_last` handshake; 0 otherwise.
- **Beat handling:**
  - `in_valid` is ignored when `in_ready`=0.
  - `blk_ready` is ignored when `blk_valid`=0.
  - `in_zero` without `in_last`: the beat is consumed with no effect.
- **Length arithmetic:** modulo 2^64. Bit length = 8 × (accepted bytes), wrapping.

## Timing
- **Reset values:**
  - `blk_valid`=0, `blk_first`=0, `blk_last`=0, `blk_data`=0, `in_ready`=0 while `reset` is high.
  - State FILL, `idx`=0, `byte_cnt`=0. `in_ready`=1 the first cycle after `reset` falls.
- **Full non-final block:** byte 63 accepted at edge N; `blk_valid`=1 from cycle N+1.
- **Final byte:** accepted at edge N; PAD during cycle N+1; `blk_valid` from N+2.
- **LENBLK:** the length-only block's `blk_valid` rises 2 cycles after the preceding handshake.
- **Back-to-back messages:** `in_ready` returns 1 in the cycle after the `blk_last` handshake. The minimum message-to-message gap is 2 cycles.
- **Reset mid-message or mid-EMIT:** the partial message is discarded; the next block is `blk_first`=1 with a length counting only new bytes.

## Structure
- **Package `md5_pkg`:**
  - `MD5_BLOCK_BYTES`=64
  - `MD5_LEN_OFFSET`=56
  - `MD5_PAD_BYTE`=8'h80
  - FSM state enum (FILL, PAD, LENBLK, EMIT)
- **Module:** single module, no sub-module. The byte-lane write decoder is an internal function.

## Test plan
- **"abc"** (61,62,63, `in_last`): one block with `blk_first`=`blk_last`=1, `blk_data[31:0]`=32'h80636261, `blk_data[511:448]`=64'h18, all else 0.
- **Empty message** (`in_zero`+`in_last`): one block, byte0=0x80, everything else 0, first=last=1.
- **55 bytes 0x41:** single block, byte55=0x80, bytes56..57=B8,01 (440 bits).
- **56 bytes:**
  - Block 1: byte56=0x80, first=1, last=0.
  - Block 2: zeros except length 64'h1C0, first=0, last=1.
- **64 bytes:**
  - Block 1: data only, last=0.
  - Block 2: byte0=0x80, length 64'h200, last=1.
  - `blk_valid` timing per Timing.
- **Backpressure and mid-message reset:**
  - Hold `blk_ready`=0 for 10 cycles: `blk_data` is stable and `in_ready`=0 throughout.
  - Assert `reset` mid-message: outputs go to their reset values; a following "abc" reproduces test 1 exactly.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared constants and FSM encoding for the MD5 message padder.
package md5_pkg;

  localparam int MD5_BLOCK_BYTES = 64;
  localparam int MD5_LEN_OFFSET  = 56;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    LENBLK,
    EMIT
  } md5_state_e;

endpackage

// File: rtl/md5_block_padder.sv
// Byte-stream to padded 512-bit block converter feeding the MD5 core.
// One block buffered; the producer stalls while it waits for the core.
module md5_block_padder
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_zero,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  output logic         blk_first,
  output logic         blk_last,
  input  logic         blk_ready
);

  localparam int CNT_W = LEN_W - 3;

  md5_state_e r_state, w_state;

  logic [511:0]     r_buf, w_buf;
  logic [6:0]       r_idx, w_idx;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_first_pend, w_first_pend;
  logic             r_blk_first, w_blk_first;
  logic             r_blk_last, w_blk_last;
  logic             r_done, w_done;
  logic             r_owe80, w_owe80;

  logic [LEN_W-1:0] w_bits;
  logic [63:0]      w_len;

  assign w_bits = {r_cnt, 3'b000};

  if (LEN_W >= 64) begin : g_trunc
    assign w_len = w_bits[63:0];
  end else begin : g_ext
    assign w_len = {{(64-LEN_W){1'b0}}, w_bits};
  end

  function automatic logic [511:0] put_byte(
    input logic [511:0] b,
    input logic [5:0]   idx,
    input logic [7:0]   v
  );
    logic [511:0] r;
    r = b;
    r[{idx, 3'b000} +: 8] = v;
    return r;
  endfunction

  function automatic logic [511:0] put_len(
    input logic [511:0] b,
    input logic [63:0]  len
  );
    logic [511:0] r;
    r = b;
    r[MD5_LEN_OFFSET*8 +: 64] = len;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_first_pend <= 1'b1;
      r_blk_first  <= 1'b0;
      r_blk_last   <= 1'b0;
      r_done       <= 1'b0;
      r_owe80      <= 1'b0;
    end else begin
      r_buf        <= w_buf;
      r_idx        <= w_idx;
      r_cnt        <= w_cnt;
      r_first_pend <= w_first_pend;
      r_blk_first  <= w_blk_first;
      r_blk_last   <= w_blk_last;
      r_done       <= w_done;
      r_owe80      <= w_owe80;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_buf        = r_buf;
    w_idx        = r_idx;
    w_cnt        = r_cnt;
    w_first_pend = r_first_pend;
    w_blk_first  = r_blk_first;
    w_blk_last   = r_blk_last;
    w_done       = r_done;
    w_owe80      = r_owe80;
    unique case (r_state)
      FILL: begin
        if (in_valid) begin
          if (!in_zero) begin
            w_buf = put_byte(r_buf, r_idx[5:0], in_data);
            w_idx = r_idx + 7'd1;
            w_cnt = r_cnt + CNT_W'(1);
          end
          if (in_last) begin
            w_state = PAD;
            w_done  = 1'b1;
          end else if (!in_zero &&
                       r_idx == 7'(MD5_BLOCK_BYTES-1)) begin
            w_state     = EMIT;
            w_blk_first = r_first_pend;
            w_blk_last  = 1'b0;
          end
        end
      end
      PAD: begin
        w_state     = EMIT;
        w_blk_first = r_first_pend;
        w_blk_last  = 1'b0;
        // idx==64: the marker moves into the length-only block
        if (r_idx[6]) begin
          w_owe80 = 1'b1;
        end else begin
          w_owe80 = 1'b0;
          w_buf   = put_byte(r_buf, r_idx[5:0], MD5_PAD_BYTE);
          if (r_idx <= 7'(MD5_LEN_OFFSET-1)) begin
            w_buf      = put_len(w_buf, w_len);
            w_blk_last = 1'b1;
          end
        end
      end
      LENBLK: begin
        w_buf = r_owe80 ?
          put_byte(r_buf, 6'd0, MD5_PAD_BYTE) : r_buf;
        w_buf       = put_len(w_buf, w_len);
        w_owe80     = 1'b0;
        w_blk_first = r_first_pend;
        w_blk_last  = 1'b1;
        w_state     = EMIT;
      end
      EMIT: begin
        if (blk_ready) begin
          w_buf        = '0;
          w_idx        = '0;
          w_first_pend = 1'b0;
          if (r_blk_last) begin
            w_cnt        = '0;
            w_first_pend = 1'b1;
            w_done       = 1'b0;
            w_state      = FILL;
          end else if (r_done) begin
            w_state = LENBLK;
          end else begin
            w_state = FILL;
          end
        end
      end
      default: w_state = FILL;
    endcase
  end

  assign in_ready  = ~reset & (r_state == FILL);
  assign blk_valid = ~reset & (r_state == EMIT);
  assign blk_first = blk_valid & r_blk_first;
  assign blk_last  = blk_valid & r_blk_last;
  assign blk_data  = reset ? '0 : r_buf;

endmodule

// File: tb/tb_md5_block_padder.sv
// Directed bench for md5_block_padder.
// Blocks are collected by a monitor and compared to hand-built images.
module tb_md5_block_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_zero;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [511:0] q_data[$];
  logic         q_first[$];
  logic         q_last[$];
  int           q_cyc[$];

  md5_block_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_zero   (in_zero),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ready (blk_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (blk_valid && blk_ready) begin
      q_data.push_back(blk_data);
      q_first.push_back(blk_first);
      q_last.push_back(blk_last);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(
    input string        tag,
    input logic [511:0] got,
    input logic [511:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(
    input logic [7:0] d,
    input logic       last,
    input logic       zero
  );
    int n;
    n = 0;
    in_data  = d;
    in_last  = last;
    in_zero  = zero;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_zero  = 1'b0;
  endtask

  task automatic send_seq(input int n, input logic last);
    for (int i = 0; i < n; i++)
      send(8'(i), last && (i == n-1), 1'b0);
  endtask

  task automatic wait_blk(input int n);
    int k;
    k = 0;
    while (q_data.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (q_data.size() < n) chk("blk_timeout", q_data.size(), n);
  endtask

  task automatic pop(
    output logic [511:0] d,
    output logic         f,
    output logic         l,
    output int           c
  );
    d = '0; f = 1'b0; l = 1'b0; c = 0;
    if (q_data.size() != 0) begin
      d = q_data.pop_front();
      f = q_first.pop_front();
      l = q_last.pop_front();
      c = q_cyc.pop_front();
    end
  endtask

  logic [511:0] d, e, abc, d0;
  logic         f, l;
  int           c1, c2;

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_zero   = 1'b0;
    blk_ready = 1'b1;
    abc = '0;
    abc[31:0]    = 32'h80636261;
    abc[511:448] = 64'h18;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", blk_valid, 0);
    chk("rst_first", blk_first, 0);
    chk("rst_last", blk_last, 0);
    chk("rst_data", blk_data, '0);
    reset = 1'b0;
    #1;
    chk("rst_rel_ready", in_ready, 1);
    @(negedge clk);

    // "abc" with latency check: PAD cycle, then valid
    send(8'h61, 0, 0);
    send(8'h62, 0, 0);
    send(8'h63, 1, 0);
    chk("abc_pad_valid", blk_valid, 0);
    @(negedge clk);
    chk("abc_valid", blk_valid, 1);
    wait_blk(1);
    pop(d, f, l, c1);
    chk("abc_data", d, abc);
    chk("abc_first", f, 1);
    chk("abc_last", l, 1);

    // 55 bytes of 'A' with a stray zero beat in the middle
    for (int i = 0; i < 55; i++) begin
      if (i == 20) send(8'hFF, 0, 1);
      send(8'h41, i == 54, 0);
    end
    wait_blk(1);
    pop(d, f, l, c1);
    e = '0;
    for (int i = 0; i < 55; i++) e[8*i +: 8] = 8'h41;
    e[55*8 +: 8] = 8'h80;
    e[463:448]   = 16'h01B8;
    chk("b55_data", d, e);
    chk("b55_fl", {f, l}, 2'b11);

    // 56 bytes: marker fills block 1, length in block 2
    send_seq(56, 1);
    wait_blk(2);
    pop(d, f, l, c1);
    e = '0;
    for (int i = 0; i < 56; i++) e[8*i +: 8] = 8'(i);
    e[56*8 +: 8] = 8'h80;
    chk("b56a_data", d, e);
    chk("b56a_fl", {f, l}, 2'b10);
    pop(d, f, l, c2);
    e = '0;
    e[511:448] = 64'h1C0;
    chk("b56b_data", d, e);
    chk("b56b_fl", {f, l}, 2'b01);
    chk("b56b_gap", c2 - c1, 2);

    // 64 bytes ending on the last lane
    for (int i = 0; i < 64; i++) begin
      if (i < 63) send(8'(i), 0, 0);
    end
    send(8'd63, 1, 0);
    chk("b64_pad_valid", blk_valid, 0);
    @(negedge clk);
    chk("b64_valid", blk_valid, 1);
    wait_blk(2);
    pop(d, f, l, c1);
    e = '0;
    for (int i = 0; i < 64; i++) e[8*i +: 8] = 8'(i);
    chk("b64a_data", d, e);
    chk("b64a_fl", {f, l}, 2'b10);
    pop(d, f, l, c2);
    e = '0;
    e[7:0]     = 8'h80;
    e[511:448] = 64'h200;
    chk("b64b_data", d, e);
    chk("b64b_fl", {f, l}, 2'b01);
    chk("b64b_gap", c2 - c1, 2);

    // 64 bytes, then a tail-only zero beat ends the message
    send_seq(64, 0);
    chk("full_valid_n1", blk_valid, 1);
    send(8'h00, 1, 1);
    wait_blk(2);
    pop(d, f, l, c1);
    e = '0;
    for (int i = 0; i < 64; i++) e[8*i +: 8] = 8'(i);
    chk("tail_a_data", d, e);
    chk("tail_a_fl", {f, l}, 2'b10);
    pop(d, f, l, c1);
    e = '0;
    e[7:0]     = 8'h80;
    e[511:448] = 64'h200;
    chk("tail_b_data", d, e);
    chk("tail_b_fl", {f, l}, 2'b01);

    // Backpressure: data held, input stalled, stray beats ignored
    blk_ready = 1'b0;
    send(8'h61, 0, 0);
    send(8'h62, 0, 0);
    send(8'h63, 1, 0);
    for (int k = 0; k < 20 && !blk_valid; k++) @(negedge clk);
    d0 = blk_data;
    chk("bp_data", d0, abc);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", blk_data, d0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", blk_valid, 1);
    end
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    wait_blk(1);
    pop(d, f, l, c1);
    chk("bp_fl", {f, l}, 2'b11);

    // Empty message: a stray byte above would show up as length
    send(8'h00, 1, 1);
    wait_blk(1);
    pop(d, f, l, c1);
    e = '0;
    e[7:0] = 8'h80;
    chk("empty_data", d, e);
    chk("empty_fl", {f, l}, 2'b11);

    // Reset mid-message, then "abc" must match the first result
    send_seq(10, 0);
    reset = 1'b1;
    #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_valid", blk_valid, 0);
    chk("mrst_data", blk_data, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_ready", in_ready, 1);
    chk("mrst_noblk", q_data.size(), 0);
    send(8'h61, 0, 0);
    send(8'h62, 0, 0);
    send(8'h63, 1, 0);
    wait_blk(1);
    pop(d, f, l, c1);
    chk("mrst_abc", d, abc);
    chk("mrst_fl", {f, l}, 2'b11);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
